// File: rtl/param_fir_filter.sv
// rtl/param_fir_filter.sv - parametrised time-multiplexed FIR filter with coefficient RAM port
module param_fir_filter #(
    parameter int IN_W     = 3,
    parameter int COEF_W   = 16,
    parameter int OUT_W    = 16,
    parameter int MAX_TAP  = 40,
    parameter int NUM_LANE = 4,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 0
) (
    input  logic                             iClk12M,
    input  logic                             iRsn,
    input  logic                             iEnSample,
    input  logic                             iCoeffUpdateFlag,
    input  logic signed [IN_W-1:0]           iFirIn,
    input  logic [$clog2(MAX_TAP+1)-1:0]     iNumOfCoeff,
    input  logic                             iCsnRam,
    input  logic                             iWrnRam,
    input  logic [$clog2(MAX_TAP)-1:0]       iAddrRam,
    input  logic [COEF_W-1:0]                iWrDtRam,
    output logic [COEF_W-1:0]                oRdDtRam,
    output logic signed [OUT_W-1:0]          oFirOut,
    output logic                             oFirValid,
    output logic                             oBusy,
    output logic                             oOverrun,
    output logic                             oSat
);

    localparam int TPL    = MAX_TAP / NUM_LANE;
    localparam int K_W    = (TPL > 1) ? $clog2(TPL) : 1;
    localparam int NTAP_W = $clog2(MAX_TAP + 1);
    localparam int ADDR_W = $clog2(MAX_TAP);
    localparam int PROD_W = IN_W + COEF_W;
    localparam int SUM_W  = ACC_W + $clog2(NUM_LANE);
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic [K_W-1:0]    K_LAST  = K_W'(TPL - 1);
    localparam logic [NTAP_W-1:0] TAP_MAX = NTAP_W'(MAX_TAP);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SUM, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic [NTAP_W-1:0]        ntap_q, ntap_d;
    logic signed [COEF_W-1:0] coef_q  [MAX_TAP];
    logic signed [COEF_W-1:0] coef_d  [MAX_TAP];
    logic signed [IN_W-1:0]   delay_q [MAX_TAP];
    logic signed [IN_W-1:0]   delay_d [MAX_TAP];
    logic signed [ACC_W-1:0]  acc_q   [NUM_LANE];
    logic signed [ACC_W-1:0]  acc_d   [NUM_LANE];
    logic signed [SUM_W-1:0]  total_q, total_d;
    logic [COEF_W-1:0]        rd_q, rd_d;
    logic signed [OUT_W-1:0]  out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;
    logic                     sat_q, sat_d;

    logic                     accept;
    logic                     addr_ok;
    logic signed [PROD_W-1:0] prod;
    logic [ADDR_W-1:0]        t_idx;
    logic signed [SUM_W-1:0]  scaled;

    always_comb begin
        addr_ok = (int'(iAddrRam) < MAX_TAP);
        accept  = iEnSample && !iCoeffUpdateFlag && (state_q == S_IDLE);
        state_d = state_q;
        k_d     = k_q;
        ntap_d  = ntap_q;
        coef_d  = coef_q;
        delay_d = delay_q;
        acc_d   = acc_q;
        total_d = total_q;
        rd_d    = rd_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        sat_d   = sat_q;
        prod    = '0;
        t_idx   = '0;
        scaled  = total_q >>> SHIFT;

        if (!iCsnRam && !iWrnRam && iCoeffUpdateFlag && addr_ok)
            coef_d[iAddrRam] = iWrDtRam;
        if (!iCsnRam && iWrnRam)
            rd_d = addr_ok ? coef_q[iAddrRam] : '0;

        if (iCoeffUpdateFlag)
            ovr_d = 1'b0;
        else if (iEnSample && (state_q != S_IDLE))
            ovr_d = 1'b1;

        if (accept) begin
            for (int t = MAX_TAP - 1; t > 0; t--)
                delay_d[t] = delay_q[t-1];
            delay_d[0] = iFirIn;
            ntap_d     = (iNumOfCoeff > TAP_MAX) ? TAP_MAX : iNumOfCoeff;
            for (int l = 0; l < NUM_LANE; l++)
                acc_d[l] = '0;
            k_d     = '0;
            state_d = S_MAC;
        end else if (iCoeffUpdateFlag) begin
            // coefficient update aborts any computation in flight
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_MAC: begin
                    for (int l = 0; l < NUM_LANE; l++) begin
                        t_idx = ADDR_W'(l * TPL + int'(k_q));
                        prod  = (NTAP_W'(t_idx) < ntap_q)
                              ? PROD_W'(delay_q[t_idx]) * PROD_W'(coef_q[t_idx]) : '0;
                        acc_d[l] = acc_q[l] + ACC_W'(prod);
                    end
                    if (k_q == K_LAST)
                        state_d = S_SUM;
                    else
                        k_d = k_q + K_W'(1);
                end
                S_SUM: begin
                    total_d = '0;
                    for (int l = 0; l < NUM_LANE; l++)
                        total_d = total_d + SUM_W'(acc_q[l]);
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (scaled > OUT_MAX) begin
                        out_d = {1'b0, {(OUT_W-1){1'b1}}};
                        sat_d = 1'b1;
                    end else if (scaled < OUT_MIN) begin
                        out_d = {1'b1, {(OUT_W-1){1'b0}}};
                        sat_d = 1'b1;
                    end else begin
                        out_d = scaled[OUT_W-1:0];
                        sat_d = 1'b0;
                    end
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            ntap_q  <= '0;
            for (int i = 0; i < MAX_TAP; i++) begin
                coef_q[i]  <= '0;
                delay_q[i] <= '0;
            end
            for (int l = 0; l < NUM_LANE; l++)
                acc_q[l] <= '0;
            total_q <= '0;
            rd_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ntap_q  <= ntap_d;
            coef_q  <= coef_d;
            delay_q <= delay_d;
            acc_q   <= acc_d;
            total_q <= total_d;
            rd_q    <= rd_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            sat_q   <= sat_d;
        end
    end

    assign oRdDtRam  = rd_q;
    assign oFirOut   = out_q;
    assign oFirValid = valid_q;
    assign oBusy     = (state_q != S_IDLE);
    assign oOverrun  = ovr_q;
    assign oSat      = sat_q;

endmodule

// File: tb/tb_param_fir_filter.sv
// tb/tb_param_fir_filter.sv - directed self-checking bench for param_fir_filter
module tb_param_fir_filter;

    localparam int IN_W    = 3;
    localparam int COEF_W  = 16;
    localparam int OUT_W   = 16;
    localparam int MAX_TAP = 40;

    logic                    iClk12M = 1'b0;
    logic                    iRsn = 1'b0;
    logic                    iEnSample = 1'b0;
    logic                    iCoeffUpdateFlag = 1'b0;
    logic signed [IN_W-1:0]  iFirIn = '0;
    logic [5:0]              iNumOfCoeff = '0;
    logic                    iCsnRam = 1'b1;
    logic                    iWrnRam = 1'b1;
    logic [5:0]              iAddrRam = '0;
    logic [COEF_W-1:0]       iWrDtRam = '0;
    logic [COEF_W-1:0]       oRdDtRam;
    logic signed [OUT_W-1:0] oFirOut;
    logic                    oFirValid, oBusy, oOverrun, oSat;

    int n_checks = 0;
    int n_pass   = 0;
    int m_coef  [MAX_TAP];
    int m_delay [MAX_TAP];
    int m_ntap  = 0;

    param_fir_filter dut (
        .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample(iEnSample),
        .iCoeffUpdateFlag(iCoeffUpdateFlag), .iFirIn(iFirIn), .iNumOfCoeff(iNumOfCoeff),
        .iCsnRam(iCsnRam), .iWrnRam(iWrnRam), .iAddrRam(iAddrRam), .iWrDtRam(iWrDtRam),
        .oRdDtRam(oRdDtRam), .oFirOut(oFirOut), .oFirValid(oFirValid), .oBusy(oBusy),
        .oOverrun(oOverrun), .oSat(oSat)
    );

    always #5 iClk12M = ~iClk12M;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic write_coef(input int addr, input logic [COEF_W-1:0] data);
        @(negedge iClk12M);
        iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = 6'(addr); iWrDtRam = data;
        @(negedge iClk12M);
        iCsnRam = 1'b1; iWrnRam = 1'b1;
        if (iCoeffUpdateFlag && addr < MAX_TAP) m_coef[addr] = int'($signed(data));
    endtask

    task automatic read_coef(input int addr, output logic [COEF_W-1:0] v);
        @(negedge iClk12M);
        iCsnRam = 1'b0; iWrnRam = 1'b1; iAddrRam = 6'(addr);
        @(negedge iClk12M);
        iCsnRam = 1'b1;
        v = oRdDtRam;
    endtask

    task automatic set_ntap(input int n);
        iNumOfCoeff = 6'(n);
        m_ntap = (n > MAX_TAP) ? MAX_TAP : n;
    endtask

    task automatic model_shift(input logic signed [IN_W-1:0] x);
        for (int t = MAX_TAP - 1; t > 0; t--) m_delay[t] = m_delay[t-1];
        m_delay[0] = int'(x);
    endtask

    task automatic model_out(output longint e_out, output longint e_sat);
        longint acc;
        acc = 0;
        for (int t = 0; t < MAX_TAP; t++)
            if (t < m_ntap) acc += longint'(m_coef[t]) * longint'(m_delay[t]);
        if (acc > 32767)       begin e_out = 32767;  e_sat = 1; end
        else if (acc < -32768) begin e_out = -32768; e_sat = 1; end
        else                   begin e_out = acc;    e_sat = 0; end
    endtask

    task automatic send_sample(input logic signed [IN_W-1:0] x,
                               output longint got_out, output longint got_sat);
        int cyc;
        longint e_out, e_sat;
        model_shift(x);
        model_out(e_out, e_sat);
        @(negedge iClk12M);
        iEnSample = 1'b1; iFirIn = x;
        cyc = 0;
        do begin
            @(negedge iClk12M);
            iEnSample = 1'b0;
            cyc++;
        end while (!oFirValid && cyc < 40);
        chk("valid_seen", longint'(oFirValid), 1);
        chk("latency", cyc, 13);
        got_out = longint'(oFirOut);
        got_sat = longint'(oSat);
        chk("model_out", got_out, e_out);
        chk("model_sat", got_sat, e_sat);
        @(negedge iClk12M);
        chk("valid_pulse", longint'(oFirValid), 0);
    endtask

    logic [COEF_W-1:0] rv;
    longint o, s;
    int     cyc;
    logic   saw;

    initial begin
        for (int t = 0; t < MAX_TAP; t++) begin m_coef[t] = 0; m_delay[t] = 0; end

        // reset state
        repeat (3) @(negedge iClk12M);
        chk("rst_out",   longint'(oFirOut), 0);
        chk("rst_valid", longint'(oFirValid), 0);
        chk("rst_busy",  longint'(oBusy), 0);
        chk("rst_ovr",   longint'(oOverrun), 0);
        chk("rst_sat",   longint'(oSat), 0);
        chk("rst_rd",    longint'(oRdDtRam), 0);
        iRsn = 1'b1;

        // coefficient port
        iCoeffUpdateFlag = 1'b1;
        write_coef(7, 16'hA5A5);
        read_coef(7, rv);        chk("rd_addr7", rv, 16'hA5A5);
        write_coef(45, 16'h1234);
        read_coef(45, rv);       chk("rd_addr45", rv, 0);
        iCoeffUpdateFlag = 1'b0;
        write_coef(8, 16'h1111);
        read_coef(8, rv);        chk("wr_no_upd", rv, 0);
        read_coef(7, rv);        chk("rd_normal_mode", rv, 16'hA5A5);

        // impulse response with coef[t] = t+1
        iCoeffUpdateFlag = 1'b1;
        for (int t = 0; t < MAX_TAP; t++) write_coef(t, 16'(t + 1));
        iCoeffUpdateFlag = 1'b0;
        set_ntap(40);
        for (int k = 0; k <= MAX_TAP; k++) begin
            send_sample((k == 0) ? 3'sd1 : 3'sd0, o, s);
            chk("impulse", o, (k < MAX_TAP) ? k + 1 : 0);
        end

        // overrun: second strobe 5 cycles after the first is dropped
        model_shift(3'sd1);
        @(negedge iClk12M); iEnSample = 1'b1; iFirIn = 3'sd1;
        @(negedge iClk12M); iEnSample = 1'b0;
        repeat (3) @(negedge iClk12M);
        iEnSample = 1'b1; iFirIn = 3'sd2;
        @(negedge iClk12M); iEnSample = 1'b0;
        chk("ovr_set", longint'(oOverrun), 1);
        cyc = 0;
        while (!oFirValid && cyc < 40) begin @(negedge iClk12M); cyc++; end
        chk("ovr_valid", longint'(oFirValid), 1);
        chk("ovr_first_out", longint'(oFirOut), 1);
        send_sample(3'sd0, o, s);
        chk("ovr_no_shift", o, 2);
        chk("ovr_sticky", longint'(oOverrun), 1);
        @(negedge iClk12M); iCoeffUpdateFlag = 1'b1;
        @(negedge iClk12M); iCoeffUpdateFlag = 1'b0;
        chk("ovr_clear", longint'(oOverrun), 0);

        // abort at MAC k=4
        model_shift(3'sd1);
        @(negedge iClk12M); iEnSample = 1'b1; iFirIn = 3'sd1;
        @(negedge iClk12M); iEnSample = 1'b0;
        repeat (4) @(negedge iClk12M);
        chk("abort_busy_before", longint'(oBusy), 1);
        iCoeffUpdateFlag = 1'b1;
        @(negedge iClk12M);
        chk("abort_busy_after", longint'(oBusy), 0);
        iCoeffUpdateFlag = 1'b0;
        saw = 1'b0;
        repeat (20) begin @(negedge iClk12M); if (oFirValid) saw = 1'b1; end
        chk("abort_no_valid", longint'(saw), 0);

        // tap clamp
        iCoeffUpdateFlag = 1'b1;
        for (int t = 0; t < MAX_TAP; t++) write_coef(t, 16'd100);
        iCoeffUpdateFlag = 1'b0;
        set_ntap(5);
        for (int k = 1; k <= 6; k++) begin
            send_sample(3'sd3, o, s);
            if (k >= 5) chk("clamp5_settle", o, 1500);
        end
        set_ntap(0);
        send_sample(3'sd3, o, s);
        chk("ntap0", o, 0);
        set_ntap(63);
        send_sample(3'sd3, o, s);

        // saturation
        iCoeffUpdateFlag = 1'b1;
        for (int t = 0; t < MAX_TAP; t++) write_coef(t, 16'h7FFF);
        iCoeffUpdateFlag = 1'b0;
        set_ntap(40);
        send_sample(3'sd3, o, s);
        chk("sat_pos_out", o, 32767);  chk("sat_pos_flag", s, 1);
        for (int k = 0; k < MAX_TAP; k++) send_sample(-3'sd3, o, s);
        chk("sat_neg_out", o, -32768); chk("sat_neg_flag", s, 1);
        for (int k = 0; k < MAX_TAP; k++) send_sample(3'sd0, o, s);
        chk("zero_out", o, 0);         chk("zero_flag", s, 0);
        send_sample(3'sd3, o, s);
        chk("sat_again", o, 32767);

        // asynchronous reset mid-MAC
        read_coef(3, rv);
        chk("rd_before_rst", rv, 16'h7FFF);
        @(negedge iClk12M); iEnSample = 1'b1; iFirIn = 3'sd3;
        @(negedge iClk12M); iEnSample = 1'b0;
        @(negedge iClk12M); iEnSample = 1'b1;
        @(negedge iClk12M); iEnSample = 1'b0;
        chk("pre_rst_busy", longint'(oBusy), 1);
        chk("pre_rst_ovr", longint'(oOverrun), 1);
        #2 iRsn = 1'b0;
        #1;
        chk("arst_out",   longint'(oFirOut), 0);
        chk("arst_sat",   longint'(oSat), 0);
        chk("arst_busy",  longint'(oBusy), 0);
        chk("arst_ovr",   longint'(oOverrun), 0);
        chk("arst_rd",    longint'(oRdDtRam), 0);
        chk("arst_valid", longint'(oFirValid), 0);
        @(negedge iClk12M); iRsn = 1'b1;
        read_coef(3, rv);  chk("coef3_cleared", rv, 0);
        read_coef(39, rv); chk("coef39_cleared", rv, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_fir_filter.md
Name: param_fir_filter

Overview:
- Next-generation reconfigurable FIR filter: tap count, lane count, and data/coefficient/output widths are all parametrised.
- Time-multiplexed MAC: NUM_LANE parallel lanes each iterate over TPL = MAX_TAP/NUM_LANE taps per sample.
- Adds features the fixed 40-tap filter lacks: runtime tap clamp, output scaling with saturation, busy/overrun status, abort on coefficient update.
- Sits between the sample source (600kHz-class enable) and downstream demod logic, with an internal coefficient memory written through a RAM-style port.

Parameters:
- IN_W, 3, signed input sample width.
- COEF_W, 16, signed coefficient width.
- OUT_W, 16, signed output width.
- MAX_TAP, 40, delay-line depth and coefficient count; must be a multiple of NUM_LANE.
- NUM_LANE, 4, parallel MAC lanes.
- ACC_W, 24, per-lane accumulator width; must be >= IN_W+COEF_W+clog2(TPL).
- SHIFT, 0, arithmetic right shift applied before saturation.

Ports:
- iClk12M  in  1  system clock, single clock domain.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample  in  1  one-cycle sample strobe.
- iCoeffUpdateFlag  in  1  1 = coefficient update mode.
- iFirIn  in  IN_W  signed input sample.
- iNumOfCoeff  in  clog2(MAX_TAP+1)  active tap count.
- iCsnRam  in  1  coefficient port select, active low.
- iWrnRam  in  1  0 = write, 1 = read.
- iAddrRam  in  clog2(MAX_TAP)  coefficient address.
- iWrDtRam  in  COEF_W  write data.
- oRdDtRam  out  COEF_W  registered read data.
- oFirOut  out  OUT_W  filter output, signed, saturated.
- oFirValid  out  1  one-cycle pulse when oFirOut updates.
- oBusy  out  1  computation in progress.
- oOverrun  out  1  sticky: a sample arrived while busy.
- oSat  out  1  saturation occurred on the current oFirOut.

Behaviour:
- Reset (asynchronous, iRsn=0): all outputs 0, coefficient memory 0, delay line 0, accumulators 0, FSM=IDLE. Reset mid-operation aborts the computation immediately.
- Coefficient memory:
  - Write when iCsnRam=0, iWrnRam=0, iCoeffUpdateFlag=1 and addr<MAX_TAP; otherwise the write is ignored.
  - Read when iCsnRam=0, iWrnRam=1, allowed in any mode. oRdDtRam updates on the next edge; addr>=MAX_TAP returns 0. oRdDtRam holds its value otherwise.
- Sample accept:
  - A sample is accepted when iEnSample=1, iCoeffUpdateFlag=0 and the FSM is in IDLE.
  - On the accepting edge: the delay line shifts (tap0 = iFirIn, tap[t] = old tap[t-1]), iNumOfCoeff is latched clamped to MAX_TAP, accumulators clear, FSM goes to MAC with k=0.
- Overrun: iEnSample=1 while FSM!=IDLE drops the sample (no shift) and sets oOverrun. oOverrun clears only on reset or when iCoeffUpdateFlag=1.
- Update mode: iEnSample is ignored and the delay line is held. Asserting iCoeffUpdateFlag in any non-IDLE state returns the FSM to IDLE on the next edge, with no oFirValid pulse.
- FSM states:
  - IDLE.
  - MAC: k = 0..TPL-1. Lane l adds delay[t]*coef[t] into acc_l, where t = l*TPL+k; the product is forced to 0 when t >= latched tap count. After k = TPL-1, go to SUM.
  - SUM: total = sum of acc_l in ACC_W+clog2(NUM_LANE) bits, signed. Go to OUT.
  - OUT: scaled = total >>> SHIFT (truncating). Clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Register oFirOut, oSat = clipped, oFirValid=1 for one cycle. Return to IDLE.
- oBusy = (FSM != IDLE).
- Latency: oFirOut/oFirValid update on the (TPL+2)th edge after the accepting edge; 12 cycles at the defaults. A new sample may be accepted in the cycle oFirValid is high.
- Output semantics: y[n] = sum over t < N of c[t]*x[n-t], where x[n] is the sample just accepted.
- Latched tap count 0 gives oFirOut=0 with oFirValid still pulsing.
- Accumulators wrap; the ACC_W constraint guarantees no lane overflow.

Test Plan:
- Impulse: coef[t]=t+1, N=40, SHIFT=0; feed 1 then zeros every 20 cycles -> oFirOut = 1,2,...,40 then 0, each oFirValid exactly 12 cycles after its strobe.
- Tap clamp: all coef=100, N=5, constant input 3 -> output settles at 1500 from the 5th sample. N=0 -> 0 with valid pulses. N=63 -> behaves as 40.
- Saturation: all coef=0x7FFF, N=40, input 3 -> oFirOut=0x7FFF, oSat=1. Input -3 (3'b101) -> 0x8000, oSat=1. Input 0 -> 0, oSat=0.
- Overrun: second strobe 5 cycles after the first -> oOverrun=1, delay line unchanged, first output still correct. Assert iCoeffUpdateFlag -> oOverrun=0.
- Coefficient port and abort:
  - Write 0xA5A5 at addr 7 -> readback 0xA5A5 the next cycle.
  - Write at addr 45 -> ignored; read returns 0.
  - Write with iCoeffUpdateFlag=0 -> ignored.
  - iCoeffUpdateFlag raised at MAC k=4 -> oBusy=0 next cycle, no oFirValid.
- Reset mid-MAC: drop iRsn asynchronously -> all outputs 0 before the next edge. Coefficients read back 0 after release.
